glut_fifo_feeder: RTL and testbench

- Operand buffer on the fifo side of the add/mul array blocks.
- Captures 128-bit vectors from an upstream stream (pack of four 32-bit floats).
- Returns them one per cycle when the consuming block raises fifo_read_en, as fifo_in_tvalid/fifo_in_tdata.
- Supports rewind/release so a stage can re-read the same DATA_NUM vectors across normal and self-calculating passes.

---
 rtl/glut_fifo_feeder.sv | 104 ++++++++++
 tb/tb_glut_fifo_feeder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/glut_fifo_feeder.sv
// Replayable operand buffer feeding the add/mul array: entries stay stored until released,
// so a stage can rewind and re-read the same vectors on a later pass.
module glut_fifo_feeder #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              wr_tvalid,
    input  logic [DATA_W-1:0] wr_tdata,
    output logic              wr_tready,
    input  logic              fifo_read_en,
    output logic              fifo_in_tvalid,
    output logic [DATA_W-1:0] fifo_in_tdata,
    input  logic              rewind,
    input  logic              release_en,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   stored,
    output logic [ADDR_W:0]   avail,
    output logic              overflow,
    output logic              underflow
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr, rd_ptr, base_ptr;
    logic [ADDR_W:0]   rd_ptr_nxt;
    logic              wr_ok, rd_req, rd_ok;
    logic              vld_p1;
    logic [DATA_W-1:0] rd_data_p1;

    // Pointers carry a wrap bit, so equal low bits with differing MSBs means full.
    assign full      = (wr_ptr[ADDR_W] != base_ptr[ADDR_W]) &&
                       (wr_ptr[ADDR_W-1:0] == base_ptr[ADDR_W-1:0]);
    assign empty     = (wr_ptr == rd_ptr);
    assign stored    = wr_ptr - base_ptr;
    assign avail     = wr_ptr - rd_ptr;
    assign wr_tready = !full;

    // A rewind cycle discards the read request entirely.
    assign wr_ok      = wr_tvalid && !full && !clear;
    assign rd_req     = fifo_read_en && !rewind && !clear;
    assign rd_ok      = rd_req && !empty;
    assign rd_ptr_nxt = rd_ptr + {{ADDR_W{1'b0}}, rd_ok};

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr[ADDR_W-1:0]] <= wr_tdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            base_ptr  <= '0;
            vld_p1    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            base_ptr  <= '0;
            vld_p1    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            vld_p1 <= rd_ok;
            if (wr_ok) begin
                wr_ptr <= wr_ptr + {{ADDR_W{1'b0}}, 1'b1};
            end
            if (wr_tvalid && full) begin
                overflow <= 1'b1;
            end
            if (rd_req && empty) begin
                underflow <= 1'b1;
            end
            // Release takes precedence over rewind: read position stays, base catches up.
            if (release_en) begin
                base_ptr <= rd_ptr_nxt;
                rd_ptr   <= rd_ptr_nxt;
            end else if (rewind) begin
                rd_ptr <= base_ptr;
            end else begin
                rd_ptr <= rd_ptr_nxt;
            end
        end
    end

    // Stage p1: registered RAM read port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_p1 <= '0;
        end else if (rd_ok) begin
            rd_data_p1 <= mem[rd_ptr[ADDR_W-1:0]];
        end
    end

    assign fifo_in_tvalid = vld_p1;
    assign fifo_in_tdata  = rd_data_p1;

endmodule

// File: tb/tb_glut_fifo_feeder.sv
// Randomized bench for glut_fifo_feeder against a queue-based model of stored/read entries.
module tb_glut_fifo_feeder;

    localparam int DW    = 128;
    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic          wr_tvalid = 1'b0;
    logic [DW-1:0] wr_tdata = '0;
    logic          wr_tready;
    logic          fifo_read_en = 1'b0;
    logic          fifo_in_tvalid;
    logic [DW-1:0] fifo_in_tdata;
    logic          rewind = 1'b0;
    logic          release_en = 1'b0;
    logic          full, empty, overflow, underflow;
    logic [AW:0]   stored, avail;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: q holds unreleased vectors oldest first; ri counts how many of them were read.
    logic [DW-1:0] q[$];
    int            ri = 0;
    logic          m_vld = 1'b0;
    logic [DW-1:0] m_data = '0;
    logic          m_ovf = 1'b0;
    logic          m_unf = 1'b0;

    glut_fifo_feeder #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .wr_tvalid(wr_tvalid), .wr_tdata(wr_tdata), .wr_tready(wr_tready),
        .fifo_read_en(fifo_read_en), .fifo_in_tvalid(fifo_in_tvalid), .fifo_in_tdata(fifo_in_tdata),
        .rewind(rewind), .release_en(release_en),
        .full(full), .empty(empty), .stored(stored), .avail(avail),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        ri     = 0;
        m_vld  = 1'b0;
        m_data = '0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ".tvalid"}, DW'(fifo_in_tvalid), DW'(m_vld));
        chk({ctx, ".tdata"}, fifo_in_tdata, m_data);
        chk({ctx, ".stored"}, DW'(stored), DW'(q.size()));
        chk({ctx, ".avail"}, DW'(avail), DW'(q.size() - ri));
        chk({ctx, ".full"}, DW'(full), DW'(q.size() == DEPTH));
        chk({ctx, ".empty"}, DW'(empty), DW'(q.size() == ri));
        chk({ctx, ".wr_tready"}, DW'(wr_tready), DW'(q.size() != DEPTH));
        chk({ctx, ".overflow"}, DW'(overflow), DW'(m_ovf));
        chk({ctx, ".underflow"}, DW'(underflow), DW'(m_unf));
    endtask

    task automatic step(input string ctx, input logic wv, input logic [DW-1:0] wd,
                        input logic re, input logic rw, input logic rl, input logic cl);
        bit was_full;
        wr_tvalid    = wv;
        wr_tdata     = wd;
        fifo_read_en = re;
        rewind       = rw;
        release_en   = rl;
        clear        = cl;
        @(posedge clk);
        if (cl) begin
            q.delete();
            ri    = 0;
            m_vld = 1'b0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            was_full = (q.size() == DEPTH);
            m_vld = 1'b0;
            if (re && !rw) begin
                if (ri < q.size()) begin
                    m_vld  = 1'b1;
                    m_data = q[ri];
                    ri++;
                end else begin
                    m_unf = 1'b1;
                end
            end
            if (wv) begin
                if (was_full) m_ovf = 1'b1;
                else q.push_back(wd);
            end
            if (rl) begin
                repeat (ri) void'(q.pop_front());
                ri = 0;
            end else if (rw) begin
                ri = 0;
            end
        end
        #1;
        check_all(ctx);
    endtask

    function automatic logic [DW-1:0] rnd_vec();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic do_write(input string ctx, input logic [DW-1:0] d);
        step(ctx, 1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_read(input string ctx);
        step(ctx, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input string ctx);
        step(ctx, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        model_reset();
        #12;
        check_all("reset");
        rst_n = 1'b1;
        #10;

        // Basic order then rewind replay and release
        for (int i = 1; i <= 4; i++) do_write("basic_wr", {4{32'(i)}});
        for (int i = 0; i < 4; i++) do_read("basic_rd");
        idle("basic_idle");
        step("rewind", 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) do_read("replay_rd");
        step("release", 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Fill to full, overflow, then free one entry
        for (int i = 0; i < DEPTH; i++) do_write("fill", rnd_vec());
        do_write("ovf", rnd_vec());
        do_read("full_rd");
        step("full_rel_wr", 1'b1, rnd_vec(), 1'b0, 1'b0, 1'b1, 1'b0);
        step("full_rel", 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("clear1", 1'b1, rnd_vec(), 1'b1, 1'b0, 1'b0, 1'b1);

        // Underflow, then write with simultaneous read
        do_read("unf_rd");
        step("unf_wr_rd", 1'b1, rnd_vec(), 1'b1, 1'b0, 1'b0, 1'b0);
        do_read("unf_next_rd");
        step("rw_rl", 1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0);

        // Address wrap
        for (int i = 0; i < 200; i++) do_write("wrap_fill", rnd_vec());
        for (int i = 0; i < 200; i++) step("wrap_rd", 1'b0, '0, 1'b1, 1'b0, (i == 199), 1'b0);
        for (int i = 0; i < 100; i++) do_write("wrap_wr", rnd_vec());
        for (int i = 0; i < 100; i++) do_read("wrap_rd2");
        step("wrap_rel", 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Clear during a burst
        for (int i = 0; i < 8; i++) do_write("burst_wr", rnd_vec());
        for (int i = 0; i < 3; i++) do_read("burst_rd");
        step("burst_clear", 1'b1, rnd_vec(), 1'b1, 1'b0, 1'b0, 1'b1);

        // Async reset during a burst
        for (int i = 0; i < 8; i++) do_write("rst_wr", rnd_vec());
        for (int i = 0; i < 2; i++) do_read("rst_rd");
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst.tvalid", DW'(fifo_in_tvalid), DW'(1'b0));
        chk("async_rst.stored", DW'(stored), DW'(0));
        chk("async_rst.avail", DW'(avail), DW'(0));
        #2 rst_n = 1'b1;
        fifo_read_en = 1'b0;
        idle("post_rst");

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step("rand",
                 $urandom_range(0, 99) < 60,
                 rnd_vec(),
                 $urandom_range(0, 99) < 50,
                 $urandom_range(0, 99) < 3,
                 $urandom_range(0, 99) < 5,
                 $urandom_range(0, 399) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
